// File: rtl/ls_dma_copy_if.sv
// rtl/ls_dma_copy_if.sv - command, status and local-store port bundle for ls_dma_copy
//
// Groups every non-clock/reset signal of the copy engine.
//   master : the command issuer plus the data memory (drives cmd_*, cmd_abort, mem_rdata)
//   slave  : the copy engine (drives cmd_ready, status outputs and mem_en_wr/mem_addr/mem_wdata)
//
//   cmd_valid/cmd_ready     command handshake
//   cmd_src/cmd_dst/cmd_len first source, first destination, quadword count
//   cmd_abort               stop the running transfer
//   busy/done/err/aborted   status; err and aborted qualify the done pulse
//   remaining               quadwords still to be written
//   mem_en_wr/mem_addr      memory write enable and word address
//   mem_wdata/mem_rdata     write data / read data (read data one cycle after address)

interface ls_dma_copy_if #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 7,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_src;
    logic [ADDR_WIDTH-1:0] cmd_dst;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic                  cmd_abort;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic                  aborted;
    logic [LEN_WIDTH-1:0]  remaining;
    logic                  mem_en_wr;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output cmd_valid, cmd_src, cmd_dst, cmd_len, cmd_abort, mem_rdata,
        input  cmd_ready, busy, done, err, aborted, remaining,
               mem_en_wr, mem_addr, mem_wdata
    );

    modport slave (
        input  cmd_valid, cmd_src, cmd_dst, cmd_len, cmd_abort, mem_rdata,
        output cmd_ready, busy, done, err, aborted, remaining,
               mem_en_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/ls_dma_copy.sv
// rtl/ls_dma_copy.sv - command-driven local-store quadword copy engine (memmove semantics)
//
// Copies cmd_len quadwords from cmd_src to cmd_dst over one read/write port of the
// local store, alternating a read cycle (RD) and a write cycle (WR) per quadword.
// Overlapping ranges are handled by copying downwards when dst > src.
//
// Ports:
//   clk    single clock, posedge
//   rst_n  asynchronous active-low reset
//   bus    ls_dma_copy_if.slave: command handshake, status, memory port

module ls_dma_copy #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 7,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    ls_dma_copy_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]  LEN_MAX  = LEN_WIDTH'(2 ** ADDR_WIDTH);

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] src_ptr;
    logic [ADDR_WIDTH-1:0] dst_ptr;
    logic [LEN_WIDTH-1:0]  remaining_q;
    logic                  descending;
    logic                  err_q;
    logic                  abort_q;

    logic                  accept;
    logic                  len_zero;
    logic                  len_bad;
    logic                  step;
    logic [ADDR_WIDTH-1:0] len_low;

    assign accept   = bus.cmd_valid && (state == IDLE);
    assign len_zero = (bus.cmd_len == '0);
    assign len_bad  = (bus.cmd_len > LEN_MAX);
    assign len_low  = bus.cmd_len[ADDR_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state; step marks the end of a WR cycle, when a word has been written.
    always_comb begin
        state_next = state;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    state_next = (len_zero || len_bad) ? FIN : RD;
                end
            end
            RD: begin
                state_next = bus.cmd_abort ? FIN : WR;
            end
            WR: begin
                step       = 1'b1;
                state_next = (bus.cmd_abort || remaining_q == LEN_ONE) ? FIN : RD;
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Pointers, count and completion qualifiers.
    // A length of 2**ADDR_WIDTH has zero low bits, so src+len-1 reduces to src-1,
    // which is the correct modular start for a full-ring descending copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_ptr     <= '0;
            dst_ptr     <= '0;
            remaining_q <= '0;
            descending  <= 1'b0;
            err_q       <= 1'b0;
            abort_q     <= 1'b0;
        end else if (accept) begin
            remaining_q <= bus.cmd_len;
            err_q       <= len_bad;
            abort_q     <= 1'b0;
            if (bus.cmd_dst > bus.cmd_src) begin
                descending <= 1'b1;
                src_ptr    <= bus.cmd_src + len_low - ADDR_ONE;
                dst_ptr    <= bus.cmd_dst + len_low - ADDR_ONE;
            end else begin
                descending <= 1'b0;
                src_ptr    <= bus.cmd_src;
                dst_ptr    <= bus.cmd_dst;
            end
        end else begin
            if (step) begin
                remaining_q <= remaining_q - LEN_ONE;
                src_ptr     <= descending ? src_ptr - ADDR_ONE : src_ptr + ADDR_ONE;
                dst_ptr     <= descending ? dst_ptr - ADDR_ONE : dst_ptr + ADDR_ONE;
            end
            if ((state == RD || state == WR) && bus.cmd_abort) begin
                abort_q <= 1'b1;
            end
        end
    end

    // All outputs decode from registered state; write data passes the word read in the
    // preceding RD straight through to the write port.
    assign bus.cmd_ready = (state == IDLE);
    assign bus.busy      = (state == RD) || (state == WR);
    assign bus.done      = (state == FIN);
    assign bus.err       = (state == FIN) && err_q;
    assign bus.aborted   = (state == FIN) && abort_q;
    assign bus.remaining = remaining_q;
    assign bus.mem_en_wr = (state == WR);
    assign bus.mem_addr  = (state == RD) ? src_ptr :
                           (state == WR) ? dst_ptr : '0;
    assign bus.mem_wdata = (state == WR) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_ls_dma_copy.sv
// tb/tb_ls_dma_copy.sv - self-checking bench for ls_dma_copy

module tb_ls_dma_copy;

    localparam int DW = 128;
    localparam int AW = 7;
    localparam int LW = AW + 1;
    localparam int DEPTH = 2 ** AW;

    logic clk;
    logic rst_n;

    ls_dma_copy_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

    ls_dma_copy #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    logic [DW-1:0] mem     [DEPTH];
    logic [DW-1:0] img     [DEPTH];
    logic [DW-1:0] snap    [DEPTH];
    logic [DW-1:0] exp_mem [DEPTH];
    bit            load;
    int            wr_log[$];
    int            rd_log[$];
    int            exp_wr[$];

    // Local store: synchronous read, data valid the cycle after the address.
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= img[i];
        end else begin
            bus.mem_rdata <= mem[bus.mem_addr];
            if (bus.mem_en_wr) mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    task automatic load_mem();
        for (int i = 0; i < DEPTH; i++) begin
            img[i]  = {$urandom, $urandom, $urandom, $urandom};
            snap[i] = img[i];
        end
        @(negedge clk);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Reference: the first n words of a memmove of len words, in the order they land.
    task automatic model(input int src, input int dst, input int len, input int n);
        int off;
        int a;
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = snap[i];
        exp_wr.delete();
        for (int i = 0; i < n; i++) begin
            off = (dst > src) ? (len - 1 - i) : i;
            a   = (dst + off) % DEPTH;
            exp_mem[a] = snap[(src + off) % DEPTH];
            exp_wr.push_back(a);
        end
    endtask

    function automatic int mem_diff();
        int bad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== exp_mem[i]) bad++;
        return bad;
    endfunction

    function automatic int order_diff();
        int bad = 0;
        if (wr_log.size() != exp_wr.size()) return 1000;
        foreach (exp_wr[i]) if (wr_log[i] != exp_wr[i]) bad++;
        return bad;
    endfunction

    // Issues one command and watches it to done; abort_wr>0 raises cmd_abort in that WR.
    task automatic run_cmd(input int src, input int dst, input int len, input int abort_wr,
                           output int busy_cnt, output int done_at, output logic e,
                           output logic a, output int rem);
        int wrs;
        wrs = 0; busy_cnt = 0; done_at = 0; e = 1'bx; a = 1'bx; rem = -1;
        wr_log.delete();
        rd_log.delete();
        @(negedge clk);
        bus.cmd_src   = AW'(src);
        bus.cmd_dst   = AW'(dst);
        bus.cmd_len   = LW'(len);
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (int k = 1; k <= 600; k++) begin
            bus.cmd_abort = 1'b0;
            if (bus.busy) busy_cnt++;
            if (bus.busy && !bus.mem_en_wr) rd_log.push_back(int'(bus.mem_addr));
            if (bus.mem_en_wr) begin
                wr_log.push_back(int'(bus.mem_addr));
                wrs++;
                if (wrs == abort_wr) bus.cmd_abort = 1'b1;
            end
            if (bus.done) begin
                done_at = k; e = bus.err; a = bus.aborted; rem = int'(bus.remaining);
                break;
            end
            @(negedge clk);
        end
        bus.cmd_abort = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready); end
        checks++; if ({bus.busy, bus.done, bus.err, bus.aborted, bus.mem_en_wr} !== 5'b0) begin
            fails++; $display("FAIL reset_flags: got %b want 00000", {bus.busy, bus.done, bus.err, bus.aborted, bus.mem_en_wr}); end
        checks++; if (bus.remaining !== '0 || bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
            fails++; $display("FAIL reset_values: remaining %0d addr %0d wdata %h want 0", bus.remaining, bus.mem_addr, bus.mem_wdata); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int b, d, r; logic e, a;
        load_mem();
        run_cmd(10, 40, 4, 0, b, d, e, a, r);
        model(10, 40, 4, 4);
        checks++; if (b != 8) begin fails++; $display("FAIL basic_busy_cycles: got %0d want 8", b); end
        checks++; if (d != 9) begin fails++; $display("FAIL basic_done_cycle: got %0d want 9", d); end
        checks++; if (e !== 1'b0 || a !== 1'b0) begin fails++; $display("FAIL basic_err_aborted: got %b%b want 00", e, a); end
        checks++; if (r != 0) begin fails++; $display("FAIL basic_remaining: got %0d want 0", r); end
        checks++; if (mem_diff() != 0) begin fails++; $display("FAIL basic_mem: %0d words differ want 0", mem_diff()); end
        checks++; if (order_diff() != 0) begin fails++; $display("FAIL basic_order: %0d differences want 0", order_diff()); end
    endtask

    task automatic test_overlap(input int src, input int dst, input string name);
        int b, d, r; logic e, a;
        load_mem();
        run_cmd(src, dst, 4, 0, b, d, e, a, r);
        model(src, dst, 4, 4);
        checks++; if (mem_diff() != 0) begin fails++; $display("FAIL %s_mem: %0d words differ want 0", name, mem_diff()); end
        checks++; if (order_diff() != 0) begin fails++; $display("FAIL %s_order: %0d differences want 0 (first write %0d)", name, order_diff(), wr_log.size() > 0 ? wr_log[0] : -1); end
    endtask

    task automatic test_wrap();
        int b, d, r; logic e, a;
        int exp_rd[4] = '{126, 127, 0, 1};
        int bad;
        load_mem();
        run_cmd(126, 60, 4, 0, b, d, e, a, r);
        model(126, 60, 4, 4);
        bad = (rd_log.size() == 4) ? 0 : 100;
        if (bad == 0) foreach (exp_rd[i]) if (rd_log[i] != exp_rd[i]) bad++;
        checks++; if (bad != 0) begin fails++; $display("FAIL wrap_read_order: %0d differences want 0", bad); end
        checks++; if (order_diff() != 0) begin fails++; $display("FAIL wrap_write_order: %0d differences want 0", order_diff()); end
        checks++; if (mem_diff() != 0) begin fails++; $display("FAIL wrap_mem: %0d words differ want 0", mem_diff()); end
    endtask

    task automatic test_edge_len();
        int b, d, r; logic e, a;
        load_mem();
        run_cmd(5, 50, 0, 0, b, d, e, a, r);
        checks++; if (d != 1 || e !== 1'b0) begin fails++; $display("FAIL len0_done: cycle %0d err %b want 1 0", d, e); end
        checks++; if (wr_log.size() != 0 || b != 0) begin fails++; $display("FAIL len0_no_access: writes %0d busy %0d want 0 0", wr_log.size(), b); end
        run_cmd(5, 50, 129, 0, b, d, e, a, r);
        checks++; if (d != 1 || e !== 1'b1) begin fails++; $display("FAIL len129_done_err: cycle %0d err %b want 1 1", d, e); end
        checks++; if (wr_log.size() != 0 || rd_log.size() != 0) begin fails++; $display("FAIL len129_no_access: writes %0d reads %0d want 0 0", wr_log.size(), rd_log.size()); end
        model(0, 0, 0, 0);
        checks++; if (mem_diff() != 0) begin fails++; $display("FAIL edge_mem_untouched: %0d words differ want 0", mem_diff()); end
        run_cmd(20, 20, 128, 0, b, d, e, a, r);
        model(20, 20, 128, 128);
        checks++; if (b != 256 || d != 257) begin fails++; $display("FAIL len128_timing: busy %0d done %0d want 256 257", b, d); end
        checks++; if (wr_log.size() != 128 || e !== 1'b0) begin fails++; $display("FAIL len128_writes: got %0d err %b want 128 0", wr_log.size(), e); end
        checks++; if (mem_diff() != 0) begin fails++; $display("FAIL len128_mem: %0d words differ want 0", mem_diff()); end
    endtask

    task automatic test_abort();
        int b, d, r; logic e, a;
        load_mem();
        run_cmd(30, 70, 8, 2, b, d, e, a, r);
        model(30, 70, 8, 2);
        checks++; if (wr_log.size() != 2) begin fails++; $display("FAIL abort_writes: got %0d want 2", wr_log.size()); end
        checks++; if (a !== 1'b1 || e !== 1'b0 || d != 5) begin fails++; $display("FAIL abort_flags: aborted %b err %b done %0d want 1 0 5", a, e, d); end
        checks++; if (r != 6) begin fails++; $display("FAIL abort_remaining: got %0d want 6", r); end
        checks++; if (mem_diff() != 0) begin fails++; $display("FAIL abort_mem: %0d words differ want 0", mem_diff()); end
        @(negedge clk);
        checks++; if (bus.remaining !== LW'(6) || bus.aborted !== 1'b0) begin
            fails++; $display("FAIL abort_hold: remaining %0d aborted %b want 6 0", bus.remaining, bus.aborted); end
    endtask

    task automatic test_reset_mid();
        int rds;
        int seen_done;
        rds = 0; seen_done = 0;
        load_mem();
        @(negedge clk);
        bus.cmd_src = AW'(30); bus.cmd_dst = AW'(80); bus.cmd_len = LW'(8); bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (int k = 0; k < 40 && rds < 3; k++) begin
            if (bus.busy && !bus.mem_en_wr) rds++;
            if (rds < 3) @(negedge clk);
        end
        checks++; if (rds != 3) begin fails++; $display("FAIL rstmid_reach_rd3: got %0d want 3", rds); end
        rst_n = 1'b0;
        #1;
        checks++; if ({bus.cmd_ready, bus.busy, bus.done, bus.err, bus.aborted, bus.mem_en_wr} !== 6'b100000
                      || bus.remaining !== '0 || bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
            fails++; $display("FAIL rstmid_outputs: flags %b remaining %0d addr %0d want 100000 0 0",
                {bus.cmd_ready, bus.busy, bus.done, bus.err, bus.aborted, bus.mem_en_wr}, bus.remaining, bus.mem_addr); end
        repeat (3) begin @(negedge clk); if (bus.done) seen_done++; end
        rst_n = 1'b1;
        repeat (3) begin @(negedge clk); if (bus.done) seen_done++; end
        checks++; if (seen_done != 0) begin fails++; $display("FAIL rstmid_no_done: got %0d pulses want 0", seen_done); end
        model(30, 80, 8, 2);
        checks++; if (mem_diff() != 0) begin fails++; $display("FAIL rstmid_partial_mem: %0d words differ want 0", mem_diff()); end
    endtask

    task automatic test_back_to_back();
        int done_q[$];
        bit ready_seen;
        ready_seen = 1'b0;
        load_mem();
        @(negedge clk);
        bus.cmd_src = AW'(10); bus.cmd_dst = AW'(50); bus.cmd_len = LW'(2); bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_src = AW'(20); bus.cmd_dst = AW'(90); bus.cmd_len = LW'(3);
        for (int k = 1; k <= 40; k++) begin
            if (ready_seen) bus.cmd_valid = 1'b0;
            if (k == 5) begin
                checks++; if (bus.cmd_ready !== 1'b0 || bus.done !== 1'b1) begin
                    fails++; $display("FAIL b2b_fin_cycle: ready %b done %b want 0 1", bus.cmd_ready, bus.done); end
            end
            if (k > 5 && bus.cmd_ready) ready_seen = 1'b1;
            if (bus.done) done_q.push_back(k);
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        checks++; if (done_q.size() != 2 || done_q[0] != 5 || done_q[1] != 13) begin
            fails++; $display("FAIL b2b_done_cycles: count %0d first %0d second %0d want 2 5 13",
                done_q.size(), done_q.size() > 0 ? done_q[0] : -1, done_q.size() > 1 ? done_q[1] : -1); end
        model(10, 50, 2, 2);
        for (int i = 0; i < DEPTH; i++) snap[i] = exp_mem[i];
        model(20, 90, 3, 3);
        checks++; if (mem_diff() != 0) begin fails++; $display("FAIL b2b_mem: %0d words differ want 0", mem_diff()); end
    endtask

    task automatic test_random();
        int b, d, r; logic e, a;
        int len, src, dst;
        for (int n = 0; n < 6; n++) begin
            len = $urandom_range(1, 30);
            src = $urandom_range(0, DEPTH - 1 - len);
            dst = $urandom_range(0, DEPTH - 1 - len);
            load_mem();
            run_cmd(src, dst, len, 0, b, d, e, a, r);
            model(src, dst, len, len);
            checks++; if (d != 2 * len + 1 || b != 2 * len) begin
                fails++; $display("FAIL rand_timing src %0d dst %0d len %0d: done %0d busy %0d want %0d %0d", src, dst, len, d, b, 2 * len + 1, 2 * len); end
            checks++; if (mem_diff() != 0 || order_diff() != 0) begin
                fails++; $display("FAIL rand_copy src %0d dst %0d len %0d: mem diff %0d order diff %0d want 0 0", src, dst, len, mem_diff(), order_diff()); end
        end
    endtask

    initial begin
        load          = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_src   = '0;
        bus.cmd_dst   = '0;
        bus.cmd_len   = '0;
        bus.cmd_abort = 1'b0;
        test_reset();
        test_basic();
        test_overlap(0, 2, "overlap_up");
        test_overlap(2, 0, "overlap_down");
        test_wrap();
        test_edge_len();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
